// File: rtl/servant_uart_rx_pkg.sv
// Shared FSM state type and Wishbone register map for the servant UART receiver.
package servant_uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int STAT_NEMPTY = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_OVR    = 2;
    localparam int STAT_FERR   = 3;

endpackage

// File: rtl/servant_uart_rx_fifo.sv
// Small byte FIFO for received characters; pointers carry one extra bit so
// full and empty can be told apart.
module servant_uart_rx_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on empty is ignored; a full FIFO still takes a push when a pop frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver with a byte FIFO, Wishbone DATA/STATUS registers and a
// level interrupt that stays high while received data is pending.
module servant_uart_rx
    import servant_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 278,
    parameter int FIFO_AW      = 2
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    input  logic        i_rxd,
    output logic        o_irq
);

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

    logic        rxd_meta;
    logic        rxs;
    rx_state_t   state;
    rx_state_t   state_d;
    logic [15:0] cnt;
    logic [15:0] cnt_d;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_d;
    logic [7:0]  shreg;
    logic [7:0]  shreg_d;
    logic        rx_push;
    logic        ferr_set;

    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic        bus_req;
    logic        rd_pop;
    logic        stat_clr;
    logic        ovr_set;
    logic        ovr;
    logic        ferr;
    logic [31:0] status_word;
    logic [31:0] data_word;

    wire unused_dat = ^{i_wb_dat[31:4], i_wb_dat[1:0]};

    // Two-flop synchronizer; idles high so a reset never looks like a start bit.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= i_rxd;
            rxs      <= rxd_meta;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
        end
    end

    // Start is re-checked at mid-bit so short glitches fall back to IDLE.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        rx_push   = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt != 16'd0) begin
                    cnt_d = cnt - 16'd1;
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (cnt != 16'd0) begin
                    cnt_d = cnt - 16'd1;
                end else begin
                    shreg_d = {rxs, shreg[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_idx == 3'd7) state_d = STOP;
                    else                 bit_idx_d = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt != 16'd0) begin
                    cnt_d = cnt - 16'd1;
                end else if (rxs) begin
                    rx_push = 1'b1;
                    state_d = IDLE;
                end else begin
                    ferr_set = 1'b1;
                    state_d  = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    servant_uart_rx_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (i_wb_clk),
        .rst_n (i_wb_rst_n),
        .push  (rx_push),
        .pop   (rd_pop),
        .din   (shreg),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus_req  = i_wb_cyc & ~o_wb_ack;
    assign rd_pop   = bus_req & ~i_wb_we & (i_wb_adr == ADDR_DATA) & ~fifo_empty;
    assign stat_clr = bus_req & i_wb_we & (i_wb_adr == ADDR_STATUS);
    assign ovr_set  = rx_push & fifo_full & ~rd_pop;

    always_comb begin
        status_word              = '0;
        status_word[STAT_NEMPTY] = ~fifo_empty;
        status_word[STAT_FULL]   = fifo_full;
        status_word[STAT_OVR]    = ovr;
        status_word[STAT_FERR]   = ferr;
        data_word                = {23'd0, ~fifo_empty, fifo_empty ? 8'h00 : fifo_dout};
    end

    // A set event in the same cycle as its write-one-to-clear keeps the flag high.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= ovr_set  | (ovr  & ~(stat_clr & i_wb_dat[STAT_OVR]));
            ferr <= ferr_set | (ferr & ~(stat_clr & i_wb_dat[STAT_FERR]));
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            o_irq    <= 1'b0;
        end else begin
            o_wb_ack <= bus_req;
            o_irq    <= ~fifo_empty;
            o_wb_rdt <= '0;
            if (bus_req && !i_wb_we) begin
                o_wb_rdt <= (i_wb_adr == ADDR_STATUS) ? status_word : data_word;
            end
        end
    end

endmodule

// File: doc/servant_uart_rx.md
Name: servant_uart_rx

Overview:
UART receiver peripheral for the servant SoC. It is the receive counterpart to the bit-banged GPIO transmit line on the board tops.
- Samples an asynchronous 8N1 serial input.
- Buffers received bytes in a small FIFO.
- Exposes data and status to the SERV core through the servant Wishbone slave interface.
- Drives a level interrupt while data is pending.

Parameters:
CLKS_PER_BIT, 278, wb_clk cycles per bit (32 MHz / 115200); legal range 8..65535
FIFO_AW, 2, log2 of FIFO depth (default depth 4)

Ports:
i_wb_clk  in  1  system clock
i_wb_rst_n  in  1  synchronous reset, active low
i_wb_adr  in  1  register select (CPU address bit 2): 0=DATA, 1=STATUS
i_wb_dat  in  32  write data
i_wb_we  in  1  write enable
i_wb_cyc  in  1  bus cycle request
o_wb_rdt  out  32  read data
o_wb_ack  out  1  bus acknowledge
i_rxd  in  1  asynchronous serial input, idle high
o_irq  out  1  high while FIFO non-empty

Behaviour:
Reset:
- Reset is synchronous and active-low; one clock (i_wb_clk).
- While i_wb_rst_n=0 at a clock edge: FSM goes to IDLE, FIFO pointers clear (empty), sticky flags clear, o_wb_ack=0, o_wb_rdt=0, o_irq=0.
- Synchronizer flops reset to 1.
- Reset mid-frame aborts the frame; no partial byte is pushed.

Input path:
- i_rxd passes through a 2-flop synchronizer; rxs denotes the synchronizer output.

FSM and bit counter (16-bit cycle counter, 3-bit bit index):
- IDLE: on rxs=0, load counter = CLKS_PER_BIT/2 - 1 and go to START.
- START: count down to 0, then sample rxs.
  - rxs=1: false start, go to IDLE.
  - rxs=0: load counter = CLKS_PER_BIT-1, bit index = 0, go to DATA.
- DATA: at counter 0, shift rxs into shreg[7] (LSB first, right shift) and reload the counter.
  - After bit index 7, go to STOP; otherwise increment bit index.
- STOP: at counter 0, sample rxs.
  - rxs=1: push shreg; go to IDLE.
  - rxs=0: set FERR sticky, discard byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1 (break condition), then go to IDLE.

FIFO:
- Depth 2^FIFO_AW, 8 bits wide; pointers have FIFO_AW+1 bits for the full/empty distinction.
- Push while full with no pop in the same cycle: byte dropped, OVR sticky set.
- Push and pop in the same cycle while full: both performed, OVR not set.
- Push and pop in the same cycle while empty: push only (pop ignored).
- Pointers wrap modulo 2^(FIFO_AW+1).

Wishbone access:
- o_wb_ack = registered (i_wb_cyc & ~o_wb_ack): one-cycle pulse one clock after request; a held cyc gets ack on every other cycle.
- o_wb_rdt is registered with ack and is 0 whenever ack=0.
- DATA read: rdt[7:0] = FIFO head, rdt[8] = non-empty, rdt[31:9] = 0.
  - Pop occurs on the ack cycle if non-empty.
  - Read while empty returns 0 and has no side effect.
- STATUS read: bit0 = non-empty, bit1 = full, bit2 = OVR, bit3 = FERR, bits[31:4] = 0. No side effect.
- STATUS write: write-one-to-clear for bit2/bit3. A set event in the same cycle as its clear wins (flag stays 1).
- DATA writes are acked and ignored.

Latency and interrupt:
- Pushed byte appears in STATUS bit0 and o_irq on the clock after the stop-bit sample.
- o_irq is a registered copy of non-empty.

Decomposition:
- Package servant_uart_rx_pkg: FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH), register offsets ADDR_DATA=0, ADDR_STATUS=1, status bit indices.
- One sub-module: servant_uart_rx_fifo (parameter AW; push/pop/din/dout/empty/full), synchronous and reset by the same active-low synchronous reset.

Test Plan:
All scenarios use CLKS_PER_BIT=16, FIFO_AW=2.
- Reset mid-frame: send 0x55, assert i_wb_rst_n=0 after bit 3, release -> STATUS reads 0x0, o_irq=0, the next full frame 0xA3 reads correctly.
- Single byte: send 0xA5 -> o_irq rises 1 clk after the stop sample; DATA read returns 0x1A5; a second read returns 0x000; o_irq falls after the pop.
- Glitch: hold i_rxd low 4 cycles then high -> no push, STATUS=0, FSM back in IDLE.
- Overflow: send 0x01..0x05 with no reads -> STATUS=0x7 (non-empty, full, OVR); reads return 0x101..0x104, then 0x000.
- Framing: send 0x3C with stop bit 0, hold line low 100 cycles -> STATUS=0x8, no data. Then release and send 0x7E -> DATA=0x17E. STATUS write 0x8 clears FERR -> STATUS=0x0.
- Simultaneous: FIFO full, DATA read acked in the same cycle as the stop sample of 0x99 -> OVR stays 0, and 0x99 is read last after the three remaining bytes.
